// File: rtl/display_rotation_scheduler.sv
// Steps the Rotator's display mode through the enabled views on a fixed slot,
// with a freeze (hold), a manual advance (next_req) and live per-view enables.
module display_rotation_scheduler #(
  parameter int unsigned SLOT_TICKS = 200000000,
  parameter int unsigned CNT_W      = 28
) (
  input  logic       clk100Mhz,
  input  logic       rst,
  input  logic [3:0] enable_mask,
  input  logic       hold,
  input  logic       next_req,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       mode_strobe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_TICKS - 1);

  state_t           state_q;
  logic [1:0]       mode_q;
  logic             valid_q;
  logic             strobe_q;
  logic [CNT_W-1:0] timer_q;

  logic [1:0]       next_mode;
  logic [1:0]       first_mode;
  logic             slot_done;

  // Cyclic search from m+1; lands back on m itself when it is the only enabled view.
  function automatic logic [1:0] next_enabled(input logic [1:0] m, input logic [3:0] mask);
    logic [1:0] cand;
    logic       found;
    // NOTE: every local gets a value before any conditional write, so no latch can be inferred.
    next_enabled = m;
    found        = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = m + 2'(k);
      if (!found && mask[cand]) begin
        next_enabled = cand;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] lowest_enabled(input logic [3:0] mask);
    lowest_enabled = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_enabled = 2'(i);
    end
  endfunction

  always_comb begin
    next_mode  = next_enabled(mode_q, enable_mask);
    first_mode = lowest_enabled(enable_mask);
    slot_done  = (timer_q == SLOT_LAST);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100Mhz) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_mask != 4'd0) begin
            state_q  <= hold ? S_HOLD : S_SHOW;
            mode_q   <= first_mode;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
            timer_q  <= '0;
          end
        end
        default: begin
          if (enable_mask == 4'd0) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            valid_q <= 1'b0;
            timer_q <= '0;
          end else if (!enable_mask[mode_q]) begin
            // A disabled current view is replaced even while frozen.
            state_q  <= hold ? S_HOLD : S_SHOW;
            mode_q   <= next_mode;
            strobe_q <= 1'b1;
            timer_q  <= '0;
          end else if (hold) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_SHOW;
            if (next_req || slot_done) begin
              mode_q   <= next_mode;
              strobe_q <= (next_mode != mode_q);
              timer_q  <= '0;
            end else begin
              timer_q <= timer_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign mode        = mode_q;
  assign mode_valid  = valid_q;
  assign mode_strobe = strobe_q;

endmodule

// File: tb/tb_display_rotation_scheduler.sv
// Self-checking bench for display_rotation_scheduler with a 4-cycle slot.
module tb_display_rotation_scheduler;

  typedef struct packed {
    logic       rst;
    logic [3:0] mask;
    logic       hold;
    logic       nr;
    logic [1:0] mode;
    logic       valid;
    logic       strobe;
  } vec_t;

  typedef struct packed {
    logic [1:0] mode;
    logic       valid;
    logic       strobe;
  } exp_t;

  logic       clk100Mhz;
  logic       rst;
  logic [3:0] enable_mask;
  logic       hold;
  logic       next_req;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_strobe;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";
  exp_t  exp_q[$];
  vec_t  tbl[$];

  display_rotation_scheduler #(.SLOT_TICKS(4), .CNT_W(3)) dut (
    .clk100Mhz  (clk100Mhz),
    .rst        (rst),
    .enable_mask(enable_mask),
    .hold       (hold),
    .next_req   (next_req),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_strobe(mode_strobe)
  );

  initial clk100Mhz = 1'b0;
  always #5 clk100Mhz = ~clk100Mhz;

  function automatic vec_t mk(input logic r, input logic [3:0] m, input logic h,
                              input logic n, input int em, input logic ev, input logic es);
    vec_t v;
    v.rst = r; v.mask = m; v.hold = h; v.nr = n;
    v.mode = 2'(em); v.valid = ev; v.strobe = es;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; enable_mask = v.mask; hold = v.hold; next_req = v.nr;
    exp_q.push_back('{mode: v.mode, valid: v.valid, strobe: v.strobe});
    @(posedge clk100Mhz);
    #1;
    e = exp_q.pop_front();
    check({phase, " mode"},   int'(mode),        int'(e.mode));
    check({phase, " valid"},  int'(mode_valid),  int'(e.valid));
    check({phase, " strobe"}, int'(mode_strobe), int'(e.strobe));
  endtask

  // Free-running rotation with all four views enabled, counted from the entry edge.
  task automatic rotate_all(input int n);
    for (int k = 0; k < n; k++)
      step(mk(1, 4'hF, 0, 0, (k / 4) % 4, 1, (k % 4) == 0));
  endtask

  task automatic do_reset(input logic [3:0] m);
    step(mk(0, m, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b0; enable_mask = 4'h0; hold = 1'b0; next_req = 1'b0;

    // Table: full rotation, then mask 1010, then a single enabled view.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0));
    for (int k = 0; k < 17; k++)
      tbl.push_back(mk(1, 4'hF, 0, 0, (k / 4) % 4, 1, (k % 4) == 0));
    tbl.push_back(mk(0, 4'hA, 0, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1, 4'hA, 0, 0, ((k / 4) % 2 == 0) ? 1 : 3, 1, (k % 4) == 0));
    tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, k == 0));

    phase = "table";
    foreach (tbl[i]) step(tbl[i]);

    // Hold in mode 2 at timer 2; next_req during hold is dropped.
    phase = "hold";
    do_reset(4'hF);
    rotate_all(11);
    for (int i = 0; i < 10; i++)
      step(mk(1, 4'hF, 1, (i == 3) || (i == 5), 2, 1, 0));
    step(mk(1, 4'hF, 0, 0, 2, 1, 0));
    step(mk(1, 4'hF, 0, 0, 3, 1, 1));

    // Manual advance mid-slot, coincident with expiry, and back-to-back.
    phase = "next_req";
    do_reset(4'hF);
    rotate_all(6);
    step(mk(1, 4'hF, 0, 1, 2, 1, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 4'hF, 0, 0, 2, 1, 0));
    step(mk(1, 4'hF, 0, 0, 3, 1, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 4'hF, 0, 0, 3, 1, 0));
    step(mk(1, 4'hF, 0, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 4'hF, 0, 0, 0, 1, 0));
    step(mk(1, 4'hF, 0, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 4'hF, 0, 0, 1, 1, 0));
    step(mk(1, 4'hF, 0, 1, 2, 1, 1));
    step(mk(1, 4'hF, 0, 0, 2, 1, 0));
    step(mk(1, 4'hF, 0, 1, 3, 1, 1));
    step(mk(1, 4'hF, 0, 1, 0, 1, 1));

    // Live mask edits: disable current view, also while held, then empty mask.
    phase = "mask";
    do_reset(4'hF);
    rotate_all(5);
    step(mk(1, 4'hD, 0, 0, 2, 1, 1));
    step(mk(1, 4'hF, 1, 0, 2, 1, 0));
    step(mk(1, 4'hB, 1, 0, 3, 1, 1));
    step(mk(1, 4'hB, 1, 0, 3, 1, 0));
    step(mk(1, 4'h0, 0, 0, 0, 0, 0));
    step(mk(1, 4'h0, 0, 0, 0, 0, 0));
    step(mk(1, 4'h4, 0, 0, 2, 1, 1));
    for (int i = 0; i < 5; i++) step(mk(1, 4'h4, 0, 0, 2, 1, 0));

    // Reset mid-slot in mode 3, then a clean restart with a full first slot.
    phase = "midreset";
    do_reset(4'hF);
    rotate_all(15);
    do_reset(4'hF);
    rotate_all(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
